// File: rtl/sonata_reset_debounce.sv
// Board-level reset sequencer: PLL-gated power-on reset, debounced reset button
// and switches, and a heartbeat LED that restarts with every system reset.
module sonata_reset_debounce #(
    parameter int DbncClkCount   = 500,
    parameter int PorLowStart    = 5,
    parameter int PorLowEnd      = 200,
    parameter int HeartbeatCount = 5000000,
    parameter int NavWidth       = 5,
    parameter int UsrWidth       = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                pll_locked_i,
    input  logic                nrst_btn_i,
    input  logic [NavWidth-1:0] nav_sw_i,
    input  logic [UsrWidth-1:0] usr_sw_i,
    output logic                por_rst_no,
    output logic                rst_sys_no,
    output logic [NavWidth-1:0] nav_sw_o,
    output logic [UsrWidth-1:0] usr_sw_o,
    output logic                heartbeat_o
);

    // Bit 0 is the reset button, then the nav switches, then the user switches.
    localparam int NumBits = 1 + NavWidth + UsrWidth;
    localparam int CntW    = $clog2(DbncClkCount + 1);

    localparam logic [CntW-1:0]    DbncLast   = CntW'(DbncClkCount - 1);
    localparam logic [CntW-1:0]    CntZero    = {CntW{1'b0}};
    localparam logic [CntW-1:0]    CntOne     = CntW'(1);
    localparam logic [7:0]         PorStart   = 8'(PorLowStart);
    localparam logic [7:0]         PorEnd     = 8'(PorLowEnd);
    localparam logic [31:0]        HbReload   = 32'(HeartbeatCount);
    // Idle levels: button released (high), switches off after inversion (low).
    localparam logic [NumBits-1:0] IdleLvl    = {{(NavWidth + UsrWidth){1'b0}}, 1'b1};

    logic [7:0]         por_cnt_r;
    logic [NumBits-1:0] raw_s;
    logic               dbnc_hold_s;
    logic [NumBits-1:0] sync1_r;
    logic [NumBits-1:0] sync2_r;
    logic [NumBits-1:0] dbc_r;
    logic [CntW-1:0]    dbnc_cnt_r [NumBits];
    logic [31:0]        hb_cnt_r;
    logic               hb_r;

    // Power-on reset counter: advances only while the PLL is locked, saturates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            por_cnt_r <= 8'h00;
        end else if (pll_locked_i && (por_cnt_r != 8'hFF)) begin
            por_cnt_r <= por_cnt_r + 8'h01;
        end else begin
            por_cnt_r <= por_cnt_r;
        end
    end

    assign por_rst_no  = (por_cnt_r < PorStart) | (por_cnt_r >= PorEnd);
    assign raw_s       = {~usr_sw_i, ~nav_sw_i, nrst_btn_i};
    assign dbnc_hold_s = rst_i | ~por_rst_no;

    // Two-flop synchroniser for all asynchronous inputs.
    always_ff @(posedge clk_i) begin
        if (dbnc_hold_s) begin
            sync1_r <= IdleLvl;
            sync2_r <= IdleLvl;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Per-bit stability counters; an output only follows a level held DbncClkCount cycles.
    always_ff @(posedge clk_i) begin
        if (dbnc_hold_s) begin
            dbc_r <= IdleLvl;
            for (int i = 0; i < NumBits; i++) begin
                dbnc_cnt_r[i] <= CntZero;
            end
        end else begin
            for (int i = 0; i < NumBits; i++) begin
                if (sync2_r[i] == dbc_r[i]) begin
                    dbnc_cnt_r[i] <= CntZero;
                end else if (dbnc_cnt_r[i] == DbncLast) begin
                    dbc_r[i]      <= sync2_r[i];
                    dbnc_cnt_r[i] <= CntZero;
                end else begin
                    dbnc_cnt_r[i] <= dbnc_cnt_r[i] + CntOne;
                end
            end
        end
    end

    assign rst_sys_no = por_rst_no & dbc_r[0];
    assign nav_sw_o   = dbc_r[NavWidth:1];
    assign usr_sw_o   = dbc_r[NumBits-1:NavWidth+1];

    // Heartbeat: restarts high on any system reset, toggles every HeartbeatCount+1 cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i || !rst_sys_no) begin
            hb_r     <= 1'b1;
            hb_cnt_r <= HbReload;
        end else if (hb_cnt_r == 32'h0000_0000) begin
            hb_r     <= ~hb_r;
            hb_cnt_r <= HbReload;
        end else begin
            hb_r     <= hb_r;
            hb_cnt_r <= hb_cnt_r - 32'h0000_0001;
        end
    end

    assign heartbeat_o = hb_r;

endmodule

// File: tb/tb_sonata_reset_debounce.sv
// Self-checking bench for sonata_reset_debounce: random input segments plus
// directed steps, compared every cycle against a cycle-count reference model.
module tb_sonata_reset_debounce;

    localparam int Dbnc  = 4;
    localparam int HbCnt = 3;
    localparam int NavW  = 5;
    localparam int UsrW  = 8;
    localparam int NB    = 1 + NavW + UsrW;
    localparam logic [NB-1:0] Idle = {{(NB - 1){1'b0}}, 1'b1};

    logic            clk;
    logic            rst;
    logic            pll;
    logic            btn;
    logic [NavW-1:0] nav;
    logic [UsrW-1:0] usr;
    logic            por_rst_no;
    logic            rst_sys_no;
    logic [NavW-1:0] nav_sw_o;
    logic [UsrW-1:0] usr_sw_o;
    logic            heartbeat_o;

    int vectors     = 0;
    int miscompares = 0;
    int cycles      = 0;

    // Reference model state: locked-cycle count, raw sample history, debounced levels,
    // and cycles elapsed since the system reset last released.
    int            m_por_cnt = 0;
    logic [NB-1:0] m_hist [5];
    logic [NB-1:0] m_dbc = Idle;
    int            m_hb_n = 0;

    sonata_reset_debounce #(
        .DbncClkCount  (Dbnc),
        .PorLowStart   (5),
        .PorLowEnd     (200),
        .HeartbeatCount(HbCnt),
        .NavWidth      (NavW),
        .UsrWidth      (UsrW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .pll_locked_i(pll),
        .nrst_btn_i  (btn),
        .nav_sw_i    (nav),
        .usr_sw_i    (usr),
        .por_rst_no  (por_rst_no),
        .rst_sys_no  (rst_sys_no),
        .nav_sw_o    (nav_sw_o),
        .usr_sw_o    (usr_sw_o),
        .heartbeat_o (heartbeat_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic e_por();
        return (m_por_cnt < 5) || (m_por_cnt >= 200);
    endfunction

    function automatic logic e_hb();
        return ((m_hb_n / (HbCnt + 1)) % 2) == 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycles);
        end
    endtask

    task automatic model_step();
        logic          por_pre;
        logic          sys_pre;
        logic [NB-1:0] raw;
        logic          all_diff;
        por_pre = e_por();
        sys_pre = por_pre && m_dbc[0];
        raw     = {~usr, ~nav, btn};
        if (rst) begin
            m_por_cnt = 0;
            m_dbc     = Idle;
            m_hb_n    = 0;
            for (int k = 0; k < 5; k++) m_hist[k] = Idle;
        end else begin
            if (pll && m_por_cnt < 255) m_por_cnt++;
            if (!por_pre) begin
                m_dbc = Idle;
                for (int k = 0; k < 5; k++) m_hist[k] = Idle;
            end else begin
                // A level flips once the last Dbnc synchronised samples all disagree with it.
                for (int b = 0; b < NB; b++) begin
                    all_diff = 1'b1;
                    for (int k = 1; k <= Dbnc; k++) begin
                        if (m_hist[k][b] == m_dbc[b]) all_diff = 1'b0;
                    end
                    if (all_diff) m_dbc[b] = ~m_dbc[b];
                end
                for (int k = 4; k > 0; k--) m_hist[k] = m_hist[k-1];
                m_hist[0] = raw;
            end
            m_hb_n = sys_pre ? m_hb_n + 1 : 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cycles++;
        model_step();
        #1;
        check("por_rst_no", {31'd0, por_rst_no}, {31'd0, e_por()});
        check("rst_sys_no", {31'd0, rst_sys_no}, {31'd0, e_por() & m_dbc[0]});
        check("nav_sw_o", {27'd0, nav_sw_o}, {27'd0, m_dbc[NavW:1]});
        check("usr_sw_o", {24'd0, usr_sw_o}, {24'd0, m_dbc[NB-1:NavW+1]});
        check("heartbeat_o", {31'd0, heartbeat_o}, {31'd0, e_hb()});
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Random hold of 1..8 cycles; short holds exercise glitch rejection.
    task automatic random_segment();
        btn = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
        nav = NavW'($urandom);
        usr = UsrW'($urandom);
        ticks($urandom_range(1, 8));
    endtask

    task automatic idle_inputs();
        btn = 1'b1;
        nav = 5'h1F;
        usr = 8'hFF;
    endtask

    initial begin
        for (int k = 0; k < 5; k++) m_hist[k] = Idle;
        rst = 1'b1;
        pll = 1'b0;
        idle_inputs();
        ticks(3);
        check("reset_por", {31'd0, por_rst_no}, 32'd1);
        check("reset_sys", {31'd0, rst_sys_no}, 32'd1);
        check("reset_hb", {31'd0, heartbeat_o}, 32'd1);

        // Unlocked PLL: POR counter must not move.
        rst = 1'b0;
        while (cycles < 40) random_segment();
        check("unlocked_por", {31'd0, por_rst_no}, 32'd1);

        // Locked, then a lock loss mid-POR that freezes the count.
        pll = 1'b1;
        while (cycles < 140) random_segment();
        check("mid_por_low", {31'd0, por_rst_no}, 32'd0);
        pll = 1'b0;
        while (cycles < 160) random_segment();
        pll = 1'b1;
        while (cycles < 700) random_segment();

        idle_inputs();
        ticks(10);
        check("por_done", {31'd0, por_rst_no}, 32'd1);

        usr = 8'hFE;
        ticks(5);
        check("usr_not_yet", {24'd0, usr_sw_o}, 32'h00);
        tick();
        check("usr_after6", {24'd0, usr_sw_o}, 32'h01);

        nav = 5'h1B;
        ticks(2);
        nav = 5'h1F;
        ticks(8);
        check("nav_glitch", {27'd0, nav_sw_o}, 32'h00);

        btn = 1'b0;
        ticks(3);
        btn = 1'b1;
        ticks(8);
        check("btn_glitch", {31'd0, rst_sys_no}, 32'd1);

        btn = 1'b0;
        ticks(5);
        check("btn_not_yet", {31'd0, rst_sys_no}, 32'd1);
        tick();
        check("btn_after6", {31'd0, rst_sys_no}, 32'd0);

        btn = 1'b1;
        ticks(6);
        check("sys_release", {31'd0, rst_sys_no}, 32'd1);
        check("hb_first_hi", {31'd0, heartbeat_o}, 32'd1);
        ticks(3);
        check("hb_still_hi", {31'd0, heartbeat_o}, 32'd1);
        tick();
        check("hb_low", {31'd0, heartbeat_o}, 32'd0);
        ticks(4);
        check("hb_high_again", {31'd0, heartbeat_o}, 32'd1);
        ticks(2);
        btn = 1'b0;
        ticks(6);
        check("hb_forced_hi", {31'd0, heartbeat_o}, 32'd1);
        btn = 1'b1;
        ticks(20);

        // Everything active, then rst_i mid-operation.
        usr = 8'h00;
        nav = 5'h00;
        ticks(8);
        check("usr_all_on", {24'd0, usr_sw_o}, 32'hFF);
        rst = 1'b1;
        tick();
        check("rst_mid_por", {31'd0, por_rst_no}, 32'd1);
        check("rst_mid_sys", {31'd0, rst_sys_no}, 32'd1);
        check("rst_mid_nav", {27'd0, nav_sw_o}, 32'h00);
        check("rst_mid_usr", {24'd0, usr_sw_o}, 32'h00);
        check("rst_mid_hb", {31'd0, heartbeat_o}, 32'd1);
        rst = 1'b0;
        while (cycles < 1500) random_segment();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
